// File: rtl/bsg_fma_mul_round.sv
// Normalize-and-round stage after the FMA significand multiplier.
// S1 normalizes the raw product, S2 rounds to nearest-even, range-checks and packs.
module bsg_fma_mul_round #(
    parameter int unsigned exp_p = 8,
    parameter int unsigned sig_p = 23
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     sign_i,
    input  logic [exp_p+1:0]         exp_sum_i,
    input  logic [2*sig_p+1:0]       sig_prod_i,
    input  logic [1:0]               class_i,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic [exp_p+sig_p:0]     z_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic                     inexact_o
);
    localparam int unsigned W  = 2 * sig_p + 2;
    localparam int unsigned EW = exp_p + 3;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << exp_p) - 1);

    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic s1_adv, s2_adv, accept;

    // S1 state: the hidden bit is always 1 for a product in [1,4), so only the fraction is kept
    logic                  s1_v, s1_sign, s1_guard, s1_sticky;
    logic [1:0]            s1_class;
    logic signed [EW-1:0]  s1_e;
    logic [sig_p-1:0]      s1_frac;

    logic                  s2_v, s2_ovf, s2_unf, s2_inx;
    logic [exp_p+sig_p:0]  s2_z;

    logic signed [EW-1:0]  ext_e, n_e, e_r;
    logic [sig_p-1:0]      n_frac, frac_r;
    logic                  n_guard, n_sticky, up, carry;
    logic [exp_p+sig_p:0]  z_d;
    logic                  ovf_d, unf_d, inx_d;

    assign s2_adv  = ~s2_v | yumi_i;
    assign s1_adv  = ~s1_v | s2_adv;
    assign ready_o = s1_adv;
    assign accept  = v_i & ready_o;

    always_comb begin
        ext_e = {exp_sum_i[exp_p+1], exp_sum_i};
        n_e   = ext_e + EW'(sig_prod_i[W-1]);
        if (sig_prod_i[W-1]) begin
            n_frac   = sig_prod_i[W-2 -: sig_p];
            n_guard  = sig_prod_i[W-sig_p-2];
            n_sticky = |sig_prod_i[W-sig_p-3:0];
        end else begin
            n_frac   = sig_prod_i[W-3 -: sig_p];
            n_guard  = sig_prod_i[W-sig_p-3];
            n_sticky = |sig_prod_i[W-sig_p-4:0];
        end
    end

    always_comb begin
        up     = s1_guard & (s1_sticky | s1_frac[0]);
        frac_r = s1_frac + sig_p'(up);
        // Rounding an all-ones fraction up wraps it to zero and bumps the exponent (m = 2.0 -> 1.0)
        carry  = up & (&s1_frac);
        e_r    = s1_e + EW'(carry);
        z_d    = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inx_d  = 1'b0;
        unique case (s1_class)
            CLS_ZERO: z_d = {s1_sign, {(exp_p + sig_p){1'b0}}};
            CLS_INF:  z_d = {s1_sign, {exp_p{1'b1}}, {sig_p{1'b0}}};
            CLS_NAN:  z_d = {1'b0, {exp_p{1'b1}}, 1'b1, {(sig_p - 1){1'b0}}};
            default: begin
                inx_d = s1_guard | s1_sticky;
                if (e_r >= EMAX) begin
                    z_d   = {s1_sign, {exp_p{1'b1}}, {sig_p{1'b0}}};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (e_r[EW-1] || e_r == '0) begin
                    z_d   = {s1_sign, {(exp_p + sig_p){1'b0}}};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    z_d = {s1_sign, e_r[exp_p-1:0], frac_r};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_v      <= 1'b0;
            s1_sign   <= 1'b0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_class  <= '0;
            s1_e      <= '0;
            s1_frac   <= '0;
            s2_v      <= 1'b0;
            s2_z      <= '0;
            s2_ovf    <= 1'b0;
            s2_unf    <= 1'b0;
            s2_inx    <= 1'b0;
        end else begin
            if (s1_adv) s1_v <= accept;
            if (accept) begin
                s1_sign   <= sign_i;
                s1_class  <= class_i;
                s1_e      <= n_e;
                s1_frac   <= n_frac;
                s1_guard  <= n_guard;
                s1_sticky <= n_sticky;
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_z   <= z_d;
                    s2_ovf <= ovf_d;
                    s2_unf <= unf_d;
                    s2_inx <= inx_d;
                end
            end
        end
    end

    assign v_o         = s2_v;
    assign z_o         = s2_z;
    assign overflow_o  = s2_ovf;
    assign underflow_o = s2_unf;
    assign inexact_o   = s2_inx;
endmodule
